// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle signed divider: state encoding,
// divide-by-zero quotient pattern and loop counter width.
package div_pkg;
  localparam int DIV_L = 16;
  localparam int CNT_W = $clog2(DIV_L);
  localparam logic [DIV_L-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [2:0] {IDLE, ABS, ITER, SIGN, DONE} state_t;
endpackage

// File: rtl/AbsoluteValue.sv
// Two's-complement magnitude; the most-negative input maps to 2^(W-1),
// which still fits as a W-bit unsigned value.
module AbsoluteValue #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] value,
  output logic        [W-1:0] magnitude
);
  assign magnitude = value[W-1] ? W'(-value) : W'(value);
endmodule

// File: rtl/GiveSign.sv
// Applies a sign to an unsigned magnitude. Overflow flags a positive result
// of exactly 2^(W-1), which wraps to the most-negative code.
module GiveSign #(
  parameter int W = 16
) (
  input  logic        [W-1:0] magnitude,
  input  logic                negative,
  output logic signed [W-1:0] value,
  output logic                Overflow
);
  assign value    = negative ? $signed(-magnitude) : $signed(magnitude);
  assign Overflow = !negative && (magnitude == {1'b1, {(W-1){1'b0}}});
endmodule

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the quotient MSB into the partial
// remainder, keep the trial difference when it is non-negative.
module div_step #(
  parameter int L = 16
) (
  input  logic [L-1:0] rem,
  input  logic [L-1:0] q,
  input  logic [L-1:0] b_mag,
  output logic [L-1:0] rem_next,
  output logic [L-1:0] q_next
);
  logic        [L:0] shifted;
  logic signed [L:0] trial;

  // rem < |b| <= 2^(L-1), so the shifted value never reaches bit L
  always_comb begin
    shifted  = {rem, q[L-1]};
    trial    = $signed(shifted) - $signed({1'b0, b_mag});
    q_next   = {q[L-2:0], ~trial[L]};
    rem_next = trial[L] ? shifted[L-1:0] : trial[L-1:0];
  end
endmodule

// File: rtl/signed_div_sequencer.sv
// Multi-cycle signed divider controller: latch operands, take magnitudes,
// run L restoring steps, then re-apply signs to quotient and remainder.
module signed_div_sequencer
  import div_pkg::*;
#(
  parameter int L = DIV_L
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [L-1:0] dividend,
  input  logic [L-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [L-1:0] quotient,
  output logic [L-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);
  state_t                state;
  logic    [CNT_W-1:0]   cnt;
  logic signed [L-1:0]   a_reg, b_reg;
  logic    [L-1:0]       a_mag, b_mag, b_mag_reg;
  logic    [L-1:0]       rem_reg, q_reg, rem_next, q_next;
  logic                  neg_q, neg_r;
  logic signed [L-1:0]   q_signed, r_signed;
  logic                  q_ovf, unused_rem_ovf;

  AbsoluteValue #(.W(L)) u_abs_a (.value(a_reg), .magnitude(a_mag));
  AbsoluteValue #(.W(L)) u_abs_b (.value(b_reg), .magnitude(b_mag));

  div_step #(.L(L)) u_step (
    .rem(rem_reg), .q(q_reg), .b_mag(b_mag_reg),
    .rem_next(rem_next), .q_next(q_next)
  );

  GiveSign #(.W(L)) u_sign_q (
    .magnitude(q_reg), .negative(neg_q), .value(q_signed), .Overflow(q_ovf)
  );
  GiveSign #(.W(L)) u_sign_r (
    .magnitude(rem_reg), .negative(neg_r), .value(r_signed), .Overflow(unused_rem_ovf)
  );

  // Datapath registers: only meaningful while busy, so they carry no reset
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_reg <= $signed(dividend);
        b_reg <= $signed(divisor);
      end
      ABS: begin
        rem_reg   <= '0;
        q_reg     <= a_mag;
        b_mag_reg <= b_mag;
        neg_q     <= a_reg[L-1] ^ b_reg[L-1];
        neg_r     <= a_reg[L-1];
      end
      ITER: begin
        rem_reg <= rem_next;
        q_reg   <= q_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ABS;
          busy  <= 1'b1;
        end
        ABS: begin
          cnt <= '0;
          if (b_reg == '0) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= L'(DIV_ZERO_Q);
            remainder   <= a_reg;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(L-1)) state <= SIGN;
        end
        SIGN: begin
          state       <= DONE;
          done        <= 1'b1;
          quotient    <= q_signed;
          remainder   <= r_signed;
          div_by_zero <= 1'b0;
          overflow    <= q_ovf;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_div_sequencer.sv
// Scoreboard bench for signed_div_sequencer: directed operand pairs with
// hand-computed results, checked by an independent monitor on done.
module tb_signed_div_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] quotient, remainder;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  signed_div_sequencer #(.L(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("overflow", overflow, e.ov);
        check("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input logic eov, input int elat);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.lat = elat; e.acc = cyc;
    sb.push_back(e);
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 16'h0000);
    check("rst_remainder", remainder, 16'h0000);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7 with busy timing around the end of the operation
    issue(16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0, 19);
    repeat (18) @(posedge clk);
    #1;
    check("busy_edge19", busy, 1'b1);
    @(posedge clk);
    #1;
    check("busy_edge20", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_quotient", quotient, 16'h000E);
    check("hold_remainder", remainder, 16'h0002);

    issue(16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 19);
    wait_idle(40);
    issue(16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 19);
    wait_idle(40);
    issue(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 19);
    wait_idle(40);
    issue(16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 19);
    wait_idle(40);

    // divide by zero: short path, busy gone after edge 3
    issue(16'd5, 16'd0, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("dbz_busy_edge3", busy, 1'b0);
    check("dbz_hold_flag", div_by_zero, 1'b1);

    // start pulse at edge 6 of a running divide must be ignored
    issue(16'd1000, 16'hFFFD, 16'hFEB3, 16'h0001, 1'b0, 1'b0, 19);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(40);
    repeat (25) @(posedge clk);
    #1;
    check("no_second_done", sb.size(), 32'd0);
    check("busy_after_ignored", busy, 1'b0);

    issue(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 19);
    wait_idle(40);

    // asynchronous abort in the middle of the iteration loop
    issue(16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0, 19);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, 16'h0000);
    check("abort_remainder", remainder, 16'h0000);
    check("abort_dbz", div_by_zero, 1'b0);
    check("abort_ovf", overflow, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'd9, 16'd3, 16'h0003, 16'h0000, 1'b0, 1'b0, 19);
    wait_idle(40);
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/signed_div_sequencer.md
# signed_div_sequencer

Multi-cycle signed integer divider controller for the i16 ALU. Accepts a two's-complement dividend/divisor pair and converts both to magnitudes. It runs an L-step restoring shift-subtract loop, then re-applies signs to the quotient and remainder. It sits beside the single-cycle ALU and owns the DIV/REM operations; the core stalls on `busy`.

## Interface
- `L`, default 16: operand and result width in bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request; sampled only in IDLE.
- `dividend`  in  L: signed dividend; sampled on the accepting edge.
- `divisor`  in  L: signed divisor; sampled on the accepting edge.
- `busy`  out  L-independent 1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse; results valid from this cycle.
- `quotient`  out  L: signed quotient, truncated toward zero.
- `remainder`  out  L: signed remainder; takes the sign of the dividend.
- `div_by_zero`  out  1: the divisor was 0 for the last completed operation.
- `overflow`  out  1: the last operation was most-negative / -1.

## Operation
- States and transitions:
  - IDLE → ABS on `start`; operands are latched.
  - ABS → ITER normally; ABS → DONE if the divisor is 0.
  - ITER → SIGN after L steps.
  - SIGN → DONE.
  - DONE → IDLE unconditionally.
- ABS:
  - Magnitudes are latched: |a|, |b| (L-bit unsigned).
  - |most-negative| = 2^(L-1), which is a valid unsigned magnitude.
  - `neg_q` = a[L-1] XOR b[L-1]; `neg_r` = a[L-1].
- ITER, one step per cycle, counter 0..L-1:
  - Shift the partial remainder left by one, bringing in the MSB of the quotient register.
  - Compute trial = rem − |b| at width L+1.
  - If trial ≥ 0, rem ← trial and the quotient bit = 1; otherwise the quotient bit = 0.
- SIGN:
  - quotient = `neg_q` ? −q : q; remainder = `neg_r` ? −r : r.
  - `overflow` = 1 when the unsigned q is 2^(L-1) and `neg_q` = 0; the quotient output is then 0x8000 for L=16, the wrapped value.
- Divide by zero, at the ABS → DONE transition:
  - quotient = all ones, remainder = dividend, `div_by_zero` = 1, `overflow` = 0.
- Outputs are registered. They hold their values from DONE until the next DONE.
- `start` while `busy` is ignored, not queued.
- `start` held high in the DONE→IDLE cycle is accepted on the next edge, after IDLE is reached.

## Timing
- Edge 1 samples `start` and enters ABS.
- Edge 2 enters ITER. Edges 3..L+2 perform the L steps.
- Edge L+3 enters DONE with the results loaded. `done` is high for the cycle after edge L+3, which is edge 19 for L=16. Edge L+4 returns to IDLE.
- On the divide-by-zero path, `done` is high after edge 2.
- Minimum issue interval: L+4 cycles.
- `busy` rises after edge 1 and falls after edge L+4.
- Reset values of all outputs are 0, with the state in IDLE.
- Asserting `rst_n` low mid-operation aborts immediately and asynchronously: the state goes to IDLE and every output goes to 0. No `done` is produced.

## Structure
- Shared package `div_pkg`:
  - the state enum (IDLE, ABS, ITER, SIGN, DONE);
  - `DIV_ZERO_Q` = all-ones constant;
  - the counter width `$clog2(L)`.
- Reuse the existing `AbsoluteValue` for the ABS stage (two instances).
- Reuse the existing `GiveSign` for the SIGN stage (two instances). Its `Overflow` output on the quotient instance drives `overflow`.
- One natural sub-module is `div_step`:
  - purely combinational;
  - inputs: rem, q, |b|;
  - outputs: next rem and next q.
  - Unit-test it standalone.

## Test plan
- 100 / 7 → quotient 14 (0x000E), remainder 2, `done` exactly 19 edges after `start`, both flags 0.
- −100 / 7 → quotient 0xFFF2 (−14), remainder 0xFFFE (−2). Also 100 / −7 → quotient 0xFFF2, remainder 0x0002.
- 0x8000 / 0xFFFF → quotient 0x8000, remainder 0, `overflow` = 1. Also 0x8000 / 1 → quotient 0x8000, `overflow` = 0.
- 5 / 0 → `done` after edge 2, quotient 0xFFFF, remainder 5, `div_by_zero` = 1, `busy` low after edge 3.
- Pulse `start` with new operands at edge 6 of a running divide → ignored; the original result arrives unchanged and no second `done` follows.
- Drive `rst_n` low mid-ITER → `busy`, `done`, quotient, remainder and flags go to 0 immediately. A subsequent 9 / 3 completes with quotient 3, remainder 0.
